// File: rtl/basic_handshake_pkg.sv
// Types shared by both ends of the valid/busy handshake.
package basic_handshake_pkg;
   localparam int DSIZE_DEFAULT = 4;
   typedef logic [DSIZE_DEFAULT-1:0] data_t;
endpackage

// File: rtl/basic_handshake_completer_fifo.sv
// Storage, wrapping read/write pointers and explicit occupancy counter.
// Any DEPTH >= 2 works; pointers wrap at DEPTH-1, not at a power of two.
module basic_handshake_completer_fifo
   import basic_handshake_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEFAULT,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DSIZE-1:0]           wdata,
   output logic [DSIZE-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [$clog2(DEPTH+1)-1:0] count_next
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);

   logic [DSIZE-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) wptr_d = (wptr_q == AW'(DEPTH-1)) ? '0 : wptr_q + AW'(1);
      if (pop)  rptr_d = (rptr_q == AW'(DEPTH-1)) ? '0 : rptr_q + AW'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Data array needs no reset: it is only observed when count is non-zero.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= wdata;
   end

   assign rdata      = mem_q[rptr_q];
   assign count      = count_q;
   assign count_next = count_d;
endmodule

// File: rtl/basic_handshake_completer.sv
// Completer end of the valid/busy handshake: FIFO, registered busy, overflow flag.
// Optional: BASIC_HANDSHAKE_COMPLETER_OVF_CHECK_EN enables sticky err_overflow + assertion.
module basic_handshake_completer
   import basic_handshake_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEFAULT,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       valid_in,
   input  logic [DSIZE-1:0]           data_in,
   output logic                       busy,
   output logic                       dout_valid,
   output logic [DSIZE-1:0]           dout,
   input  logic                       dout_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       err_overflow
);
   localparam int CW = $clog2(DEPTH+1);

   logic             push, pop, full;
   logic [CW-1:0]    count_next;
   logic [DSIZE-1:0] rdata;
   logic             busy_q, busy_d;

   assign dout_valid = (count != '0);
   assign full       = (count == CW'(DEPTH));
   assign pop        = dout_valid & dout_ready;
   // A pop on the same edge frees the slot, so a full FIFO can still accept.
   assign push       = valid_in & (~full | pop);
   assign dout       = dout_valid ? rdata : '0;

   basic_handshake_completer_fifo #(.DSIZE(DSIZE), .DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .push       (push),
      .pop        (pop),
      .wdata      (data_in),
      .rdata      (rdata),
      .count      (count),
      .count_next (count_next)
   );

   // Threshold at DEPTH-1 leaves one slot for the word already in flight.
   always_comb busy_d = (count_next >= CW'(DEPTH-1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) busy_q <= 1'b0;
      else       busy_q <= busy_d;
   end
   assign busy = busy_q;

`ifdef BASIC_HANDSHAKE_COMPLETER_OVF_CHECK_EN
   logic ovf, err_q, err_d;
   assign ovf = valid_in & full & ~pop;
   always_comb err_d = err_q | ovf;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) err_q <= 1'b0;
      else       err_q <= err_d;
   end
   assign err_overflow = err_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !ovf);
`else
   assign err_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_basic_handshake_completer.sv
// Queue-based reference model checked every cycle, plus directed literal checks.
module tb_basic_handshake_completer;
   localparam int DSIZE = 4;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             valid_in = 1'b0;
   logic [DSIZE-1:0] data_in = '0;
   logic             dout_ready = 1'b0;
   logic             busy, dout_valid, err_overflow;
   logic [DSIZE-1:0] dout;
   logic [2:0]       count;

   int checks = 0;
   int errors = 0;

`ifdef BASIC_HANDSHAKE_COMPLETER_OVF_CHECK_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   basic_handshake_completer #(.DSIZE(DSIZE), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .valid_in     (valid_in),
      .data_in      (data_in),
      .busy         (busy),
      .dout_valid   (dout_valid),
      .dout         (dout),
      .dout_ready   (dout_ready),
      .count        (count),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of accepted words and a sticky error bit.
   int q[$];
   bit err_m = 1'b0;

   always @(posedge clk) begin
      bit pop_m, push_m;
      if (!rstn) begin
         q.delete();
         err_m = 1'b0;
      end else begin
         pop_m  = (q.size() != 0) && dout_ready;
         push_m = valid_in && ((q.size() < DEPTH) || pop_m);
         if (valid_in && !push_m && OVF_EN) err_m = 1'b1;
         if (pop_m)  void'(q.pop_front());
         if (push_m) q.push_back(int'(data_in));
      end
      #1;
      chk("count", int'(count), q.size());
      chk("dout_valid", int'(dout_valid), int'(q.size() != 0));
      chk("dout", int'(dout), (q.size() != 0) ? q[0] : 0);
      chk("busy", int'(busy), int'(rstn && (q.size() >= DEPTH - 1)));
      chk("err_overflow", int'(err_overflow), int'(err_m));
   end

   task automatic drive(input bit v, input int d, input bit r);
      @(negedge clk);
      valid_in   = v;
      data_in    = DSIZE'(d);
      dout_ready = r;
      @(posedge clk);
      #2;
   endtask

   initial begin
      bit bprev;
      #3;
      chk("rst_busy", int'(busy), 0);
      chk("rst_dout_valid", int'(dout_valid), 0);
      chk("rst_dout", int'(dout), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_err", int'(err_overflow), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;

      // Single word, one-cycle latency
      drive(1, 5, 0);
      chk("single_dout", int'(dout), 5);
      chk("single_dv", int'(dout_valid), 1);
      chk("single_count", int'(count), 1);
      chk("single_busy", int'(busy), 0);
      drive(0, 0, 1);
      chk("single_pop_count", int'(count), 0);
      chk("single_pop_dout", int'(dout), 0);

      // Fill: busy after third push, fourth in-flight word still accepted
      drive(1, 1, 0);
      drive(1, 2, 0);
      chk("fill2_busy", int'(busy), 0);
      drive(1, 3, 0);
      chk("fill3_busy", int'(busy), 1);
      chk("fill3_count", int'(count), 3);
      drive(1, 4, 0);
      chk("fill4_count", int'(count), 4);
      chk("fill4_dout", int'(dout), 1);

      // Protocol violation: word dropped while full
      drive(1, 9, 0);
      chk("ovf_count", int'(count), 4);
      chk("ovf_dout", int'(dout), 1);
      chk("ovf_err", int'(err_overflow), int'(OVF_EN));
      drive(0, 0, 0);
      chk("ovf_err_sticky", int'(err_overflow), int'(OVF_EN));

      // Drain: busy holds at count 3, releases at count 2
      drive(0, 0, 1);
      chk("drain1_dout", int'(dout), 2);
      chk("drain1_busy", int'(busy), 1);
      drive(0, 0, 1);
      chk("drain2_dout", int'(dout), 3);
      chk("drain2_busy", int'(busy), 0);

      // Simultaneous push/pop at count 2, write pointer wraps
      drive(1, 6, 1);
      chk("simul1_count", int'(count), 2);
      chk("simul1_dout", int'(dout), 4);
      drive(1, 7, 1);
      chk("simul2_count", int'(count), 2);
      chk("simul2_dout", int'(dout), 6);
      drive(0, 0, 1);
      chk("wrap_dout", int'(dout), 7);
      drive(0, 0, 1);
      chk("empty_count", int'(count), 0);

      // Asynchronous reset mid-stream with count 3
      drive(1, 8, 0);
      drive(1, 8, 0);
      drive(1, 8, 0);
      chk("pre_rst_count", int'(count), 3);
      rstn = 1'b0;
      #1;
      chk("async_rst_count", int'(count), 0);
      chk("async_rst_dv", int'(dout_valid), 0);
      chk("async_rst_dout", int'(dout), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_err", int'(err_overflow), 0);
      @(negedge clk);
      valid_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      drive(1, 10, 0);
      chk("post_rst_dout", int'(dout), 10);
      chk("post_rst_count", int'(count), 1);
      drive(0, 0, 1);

      // Randomized traffic; requester honours busy one edge late
      bprev = 1'b1;
      repeat (3000) begin
         @(negedge clk);
         valid_in   = !bprev && ($urandom_range(0, 3) != 0);
         data_in    = DSIZE'($urandom_range(0, 15));
         dout_ready = ($urandom_range(0, 2) != 0);
         bprev      = busy;
      end
      @(negedge clk);
      valid_in = 1'b0;
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
